// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive port: receive FSM state encoding,
// port-window register offsets, STATUS bit positions and the default bit
// period (50 MHz / 115200 baud).
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

  // Register window offsets (selected by the 1-bit addr line)
  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  // STATUS register bit positions
  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_FRAMING   = 3;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage : uart_pkg

// File: rtl/uart_rx_port_if.sv
// ---------------------------------------------------------------------------
// uart_rx_port_if
// CPU port-bus window of the UART receiver.
//   en       access strobe (already qualified by the port-ID decode)
//   wr       1 = write, 0 = read
//   addr     register select: 0 = DATA, 1 = STATUS
//   data_in  CPU write data
//   data_out registered read data of the selected register
//   rx_ready FIFO not empty, registered
// master = CPU side, slave = receiver side.
// ---------------------------------------------------------------------------
interface uart_rx_port_if;
  logic       en;
  logic       wr;
  logic       addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       rx_ready;

  modport master (output en, wr, addr, data_in, input  data_out, rx_ready);
  modport slave  (input  en, wr, addr, data_in, output data_out, rx_ready);
endinterface : uart_rx_port_if

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO, 2**DEPTH_LOG2 entries of WIDTH bits.
//   clk, reset      clock, synchronous active-low reset
//   push_i/data_i   write request and data
//   pop_i           read request (ignored while empty)
//   head_o          entry at the read pointer (stale value while empty)
//   full_o/empty_o  occupancy flags
//   drop_o          push rejected because the FIFO was full with no pop
// A push and a pop together while full both succeed.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_push;
  logic                  do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && !do_push;
  assign head_o  = mem_q[rd_ptr_q];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; emptiness is tracked
  // by count_q, and leaving the array reset-free lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule : sync_fifo

// File: rtl/uart_rx_port.sv
// ---------------------------------------------------------------------------
// uart_rx_port
// 8N1 UART receiver with a 16-entry receive FIFO behind a two-register
// PicoBlaze port window (DATA at addr 0, STATUS at addr 1).
//   clk    system clock
//   reset  synchronous active-low reset
//   rxd    asynchronous serial input, idles high
//   bus    port window (uart_rx_port_if.slave)
// A DATA read pops the FIFO head; STATUS is write-one-to-clear for the
// sticky overrun (bit 2) and framing (bit 3) flags.
// ---------------------------------------------------------------------------
module uart_rx_port
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rxd,
  uart_rx_port_if.slave  bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync1_q, sync2_q;
  rx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             overrun_q, framing_q;
  logic [7:0]       data_out_q;
  logic             rx_ready_q;

  logic       sample_tick, push, framing_evt, pop, stat_wr;
  logic [7:0] fifo_head;
  logic       fifo_full, fifo_empty, fifo_drop;
  logic [7:0] status, rd_data;
  logic       unused_data_bits;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
    end
  end

  assign sample_tick = (cnt_q == '0);
  // The byte is pushed on the same edge the stop bit is sampled.
  assign push        = (state_q == ST_STOP) && sample_tick && sync2_q;
  assign framing_evt = (state_q == ST_STOP) && sample_tick && !sync2_q;
  assign pop         = bus.en && !bus.wr && (bus.addr == ADDR_DATA);
  assign stat_wr     = bus.en &&  bus.wr && (bus.addr == ADDR_STATUS);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!sync2_q) begin
            cnt_q   <= HALF_LOAD;  // land the start sample at mid-bit
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (!sample_tick) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (sync2_q) begin
            state_q <= ST_IDLE;    // line back high: glitch, not a start bit
          end else begin
            cnt_q     <= FULL_LOAD;
            bit_idx_q <= '0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (!sample_tick) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            shift_q <= {sync2_q, shift_q[7:1]};  // LSB arrives first
            cnt_q   <= FULL_LOAD;
            if (bit_idx_q == 3'd7) state_q <= ST_STOP;
            else                   bit_idx_q <= bit_idx_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (!sample_tick)  cnt_q   <= cnt_q - 1'b1;
          else if (sync2_q)  state_q <= ST_IDLE;
          else               state_q <= ST_WAIT_IDLE;
        end
        ST_WAIT_IDLE: begin
          if (sync2_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (shift_q),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .drop_o      (fifo_drop)
  );

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    status                 = '0;
    status[STAT_NOT_EMPTY] = !fifo_empty;
    status[STAT_FULL]      = fifo_full;
    status[STAT_OVERRUN]   = overrun_q;
    status[STAT_FRAMING]   = framing_q;
    rd_data                = status;
    if (bus.addr == ADDR_DATA) rd_data = fifo_empty ? 8'h00 : fifo_head;
  end

  // Sticky flags: a set event in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overrun_q  <= 1'b0;
      framing_q  <= 1'b0;
      data_out_q <= 8'h00;
      rx_ready_q <= 1'b0;
    end else begin
      overrun_q  <= fifo_drop   | (overrun_q & ~(stat_wr & bus.data_in[STAT_OVERRUN]));
      framing_q  <= framing_evt | (framing_q & ~(stat_wr & bus.data_in[STAT_FRAMING]));
      data_out_q <= rd_data;
      rx_ready_q <= !fifo_empty;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.rx_ready = rx_ready_q;

  // Only the two W1C bits of the write data carry meaning.
  assign unused_data_bits = ^{bus.data_in[7:4], bus.data_in[1:0]};

endmodule : uart_rx_port

// File: tb/tb_uart_rx_port.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_port
// Self-checking bench for uart_rx_port at CLKS_PER_BIT = 16. Serial frames
// are driven on rxd; each byte whose stop bit is good is pushed into an
// expected-byte queue (dropped when the modelled FIFO is full) and popped
// when the bench reads DATA. STATUS values are checked against constants.
// ---------------------------------------------------------------------------
module tb_uart_rx_port;
  import uart_pkg::*;

  localparam int CPB   = 16;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic rxd   = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q [$];

  uart_rx_port_if bus_if ();

  uart_rx_port #(
    .CLKS_PER_BIT    (CPB),
    .FIFO_DEPTH_LOG2 (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rxd   (rxd),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full 8N1 frame; expectation queued after the stop bit if it is good.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = stop;
    tick(CPB);
    rxd = 1'b1;
    if (stop && exp_q.size() < DEPTH) exp_q.push_back(b);
  endtask

  task automatic read_status(input string tag, input logic [7:0] exp);
    bus_if.en   = 1'b0;
    bus_if.addr = ADDR_STATUS;
    tick(2);
    check(tag, bus_if.data_out, exp);
  endtask

  task automatic read_data(input string tag);
    logic [7:0] exp;
    bus_if.en   = 1'b0;
    bus_if.addr = ADDR_DATA;
    tick(2);
    exp = (exp_q.size() == 0) ? 8'h00 : exp_q.pop_front();
    check(tag, bus_if.data_out, exp);
    bus_if.wr = 1'b0;
    bus_if.en = 1'b1;
    tick(1);
    bus_if.en = 1'b0;
  endtask

  task automatic write_reg(input logic a, input logic [7:0] v);
    bus_if.addr    = a;
    bus_if.data_in = v;
    bus_if.wr      = 1'b1;
    bus_if.en      = 1'b1;
    tick(1);
    bus_if.en = 1'b0;
    bus_if.wr = 1'b0;
  endtask

  initial begin
    int lat;
    bus_if.en      = 1'b0;
    bus_if.wr      = 1'b0;
    bus_if.addr    = ADDR_DATA;
    bus_if.data_in = 8'h00;

    // Reset
    tick(3);
    check("reset_data_out", bus_if.data_out, 8'h00);
    check("reset_rx_ready", {7'b0, bus_if.rx_ready}, 8'h00);
    reset = 1'b1;
    read_status("reset_status", 8'h00);

    // Single byte with ready latency
    lat = -1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int c = 1; c <= 200; c++) begin
          tick(1);
          if (bus_if.rx_ready) begin
            lat = c;
            break;
          end
        end
      end
    join
    check("ready_latency_ok", {7'b0, (lat >= 150 && lat <= 170)}, 8'h01);
    tick(4);
    read_status("single_status", 8'h01);
    read_data("single_data");
    read_status("single_status_after", 8'h00);

    // DATA write is ignored
    write_reg(ADDR_DATA, 8'hFF);
    read_status("data_write_ignored", 8'h00);

    // Glitch rejection, then a good frame
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(30);
    read_status("glitch_status", 8'h00);
    send_frame(8'h81, 1'b1);
    tick(4);
    read_data("post_glitch_data");

    // Framing error
    send_frame(8'h3C, 1'b0);
    tick(4);
    read_status("framing_status", 8'h08);
    write_reg(ADDR_STATUS, 8'h08);
    read_status("framing_cleared", 8'h00);

    // Overrun: 17 frames, no reads
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1);
    tick(4);
    read_status("overrun_status", 8'h07);
    for (int i = 0; i < DEPTH; i++) read_data($sformatf("overrun_data_%0d", i));
    read_data("overrun_empty_read");
    read_status("overrun_drained", 8'h04);
    write_reg(ADDR_STATUS, 8'h04);
    read_status("overrun_cleared", 8'h00);

    // Push/pop collision while full
    for (int i = 0; i < DEPTH; i++) send_frame(8'h20 + 8'(i), 1'b1);
    tick(4);
    read_status("collide_full", 8'h03);
    fork
      send_frame(8'hC7, 1'b1);
      begin
        bus_if.addr = ADDR_DATA;
        tick(154);  // stop-bit sample edge follows this negedge
        check("collide_head", bus_if.data_out, exp_q[0]);
        void'(exp_q.pop_front());
        bus_if.wr = 1'b0;
        bus_if.en = 1'b1;
        tick(1);
        bus_if.en = 1'b0;
      end
    join
    tick(4);
    read_status("collide_status", 8'h03);
    for (int i = 0; i < DEPTH; i++) read_data($sformatf("collide_data_%0d", i));
    read_status("collide_drained", 8'h00);

    // Reset mid-frame with a byte buffered and framing set
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b0);
    tick(4);
    read_status("pre_reset_status", 8'h09);
    rxd = 1'b0;
    tick(CPB);
    rxd = 1'b1; tick(CPB);
    rxd = 1'b0; tick(CPB);
    rxd = 1'b1; tick(CPB);
    rxd = 1'b1; tick(CPB);
    rxd = 1'b0;
    tick(CPB / 2);
    reset = 1'b0;
    tick(3);
    check("midreset_data_out", bus_if.data_out, 8'h00);
    reset = 1'b1;
    rxd   = 1'b1;
    exp_q.delete();
    tick(CPB * 12);
    check("midreset_rx_ready", {7'b0, bus_if.rx_ready}, 8'h00);
    read_status("midreset_status", 8'h00);
    send_frame(8'h5A, 1'b1);
    tick(4);
    read_status("after_reset_status", 8'h01);
    read_data("after_reset_data");
    read_status("final_status", 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_rx_port
